mcu_bus_receiver: RTL and testbench

Front-end stage for the MCU parallel bus. It sits directly upstream of the command decoder that drives the PSRAM write interface and the GPU core.
- Resynchronises the asynchronous mcu_bus_clock, mcu_bus and mcu_bus_command_data into the system_clock domain.
- Captures one byte and its command/data flag per bus-clock rising edge.
- Buffers the captured bytes in a small FIFO and presents them on a valid/ready stream.

---
 rtl/msgpu_bus_pkg.sv | 33 +++
 rtl/mcu_bus_receiver_if.sv | 51 +++++
 rtl/sync_fifo.sv | 98 +++++++++
 rtl/mcu_bus_receiver.sv | 121 ++++++++++++
 tb/tb_mcu_bus_receiver.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/msgpu_bus_pkg.sv
// ---------------------------------------------------------------------------
// msgpu_bus_pkg
// Shared definitions for the MCU parallel-bus front end: bus width, the
// command/data flag encodings and the FIFO word layout used between the
// receiver and the downstream command decoder.
// No ports (package).
// ---------------------------------------------------------------------------
package msgpu_bus_pkg;

    localparam int MCU_BUS_WIDTH = 8;

    // Value carried on mcu_bus_command_data / out_is_command.
    localparam logic CMD_FLAG  = 1'b1;
    localparam logic DATA_FLAG = 1'b0;

    // One captured bus transfer; this is the word stored in the capture FIFO.
    typedef struct packed {
        logic                     is_command;
        logic [MCU_BUS_WIDTH-1:0] data;
    } bus_entry_t;

    // Builds a FIFO word from a synchronised flag and byte.
    function automatic bus_entry_t make_entry(
        input logic                     is_command,
        input logic [MCU_BUS_WIDTH-1:0] data
    );
        bus_entry_t entry;
        entry.is_command = is_command;
        entry.data       = data;
        return entry;
    endfunction

endpackage

// File: rtl/mcu_bus_receiver_if.sv
// ---------------------------------------------------------------------------
// mcu_bus_receiver_if
// Groups the asynchronous MCU bus inputs and the valid/ready output stream of
// the MCU bus receiver.
//   master : drives the MCU bus (mcu_bus_clock, mcu_bus, mcu_bus_command_data)
//            and out_ready; observes the stream and status outputs.
//   slave  : the receiver; samples the bus and out_ready, drives out_data,
//            out_is_command, out_valid, level and overflow.
// ---------------------------------------------------------------------------
interface mcu_bus_receiver_if
    import msgpu_bus_pkg::*;
#(
    parameter int DATA_WIDTH = MCU_BUS_WIDTH,
    parameter int FIFO_DEPTH = 8
);

    logic                          mcu_bus_clock;
    logic [DATA_WIDTH-1:0]         mcu_bus;
    logic                          mcu_bus_command_data;
    logic [DATA_WIDTH-1:0]         out_data;
    logic                          out_is_command;
    logic                          out_valid;
    logic                          out_ready;
    logic [$clog2(FIFO_DEPTH):0]   level;
    logic                          overflow;

    modport master (
        output mcu_bus_clock,
        output mcu_bus,
        output mcu_bus_command_data,
        output out_ready,
        input  out_data,
        input  out_is_command,
        input  out_valid,
        input  level,
        input  overflow
    );

    modport slave (
        input  mcu_bus_clock,
        input  mcu_bus,
        input  mcu_bus_command_data,
        input  out_ready,
        output out_data,
        output out_is_command,
        output out_valid,
        output level,
        output overflow
    );

endinterface

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO. The head word is always present
// on rd_data_o while empty_o is low.
// Ports:
//   clk_i     : clock (rising edge)
//   reset_i   : synchronous active-high reset, empties the FIFO
//   push_i    : write wr_data_i at the tail (ignored when full unless popping)
//   wr_data_i : word to write
//   pop_i     : remove the head word (ignored when empty)
//   rd_data_o : head word
//   full_o    : FIFO holds DEPTH words
//   empty_o   : FIFO holds no words
//   level_o   : current occupancy (0..DEPTH)
// DEPTH must be a power of two and at least 2.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic             full_s;
    logic             empty_s;
    logic             do_push_s;
    logic             do_pop_s;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                     (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

    // A pop frees a slot in the same cycle, so a full FIFO may still accept a push.
    assign do_pop_s  = pop_i & ~empty_s;
    assign do_push_s = push_i & (~full_s | do_pop_s);

    // Next-state pointer advance.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; cleared on reset so the head word reads as zero when empty.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign full_o    = full_s;
    assign empty_o   = empty_s;
    assign level_o   = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/mcu_bus_receiver.sv
// ---------------------------------------------------------------------------
// mcu_bus_receiver
// Front end of the MCU parallel bus. Resynchronises the asynchronous bus
// strobe, byte and command/data flag into system_clock, captures one entry on
// each rising edge of the synchronised strobe and buffers it in a
// first-word-fall-through FIFO presented as a valid/ready stream.
// Ports:
//   system_clock : sole clock; all state updates on its rising edge
//   reset        : synchronous active-high reset
//   bus (slave)  : mcu_bus_clock / mcu_bus / mcu_bus_command_data inputs,
//                  out_data / out_is_command / out_valid / out_ready stream,
//                  level (FIFO occupancy) and sticky overflow
// FIFO_DEPTH must be a power of two and at least 2; SYNC_STAGES at least 2.
// ---------------------------------------------------------------------------
module mcu_bus_receiver
    import msgpu_bus_pkg::*;
#(
    parameter int DATA_WIDTH  = MCU_BUS_WIDTH,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               system_clock,
    input  logic               reset,
    mcu_bus_receiver_if.slave  bus
);

    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = $bits(bus_entry_t);

    // Stage 0 samples the pad; stage SYNC_STAGES-1 is the synchronised value.
    logic [SYNC_STAGES-1:0]                 clk_sync_q;
    logic [SYNC_STAGES-1:0]                 clk_sync_d;
    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] data_sync_q;
    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] data_sync_d;
    logic [SYNC_STAGES-1:0]                 flag_sync_q;
    logic [SYNC_STAGES-1:0]                 flag_sync_d;
    logic                                   prev_q;
    logic                                   overflow_q;
    logic                                   overflow_d;

    logic                                   push_s;
    logic                                   pop_s;
    logic                                   full_s;
    logic                                   empty_s;
    logic [LEVEL_W-1:0]                     level_s;
    bus_entry_t                             wr_entry_s;
    bus_entry_t                             rd_entry_s;
    logic [ENTRY_W-1:0]                     rd_word_s;

    // Next state of the resynchroniser chains: each new sample enters at stage 0.
    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], bus.mcu_bus_clock};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], bus.mcu_bus};
        flag_sync_d = {flag_sync_q[SYNC_STAGES-2:0], bus.mcu_bus_command_data};
    end

    // Resynchronisers and edge-detect history. The strobe chain and prev reset
    // high so a strobe already high at reset release is not seen as an edge,
    // and any rise still in flight when reset hits is discarded.
    always_ff @(posedge system_clock) begin
        if (reset) begin
            clk_sync_q  <= {SYNC_STAGES{1'b1}};
            data_sync_q <= {(SYNC_STAGES*DATA_WIDTH){1'b0}};
            flag_sync_q <= {SYNC_STAGES{1'b0}};
            prev_q      <= 1'b1;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            flag_sync_q <= flag_sync_d;
            prev_q      <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    // Rising edge of the synchronised strobe; the byte and flag travelled
    // through equally deep chains, so they line up with this edge.
    assign push_s     = clk_sync_q[SYNC_STAGES-1] & ~prev_q;
    assign wr_entry_s = make_entry(flag_sync_q[SYNC_STAGES-1], data_sync_q[SYNC_STAGES-1]);
    assign pop_s      = ~empty_s & bus.out_ready;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (system_clock),
        .reset_i   (reset),
        .push_i    (push_s),
        .wr_data_i (wr_entry_s),
        .pop_i     (pop_s),
        .rd_data_o (rd_word_s),
        .full_o    (full_s),
        .empty_o   (empty_s),
        .level_o   (level_s)
    );

    // A push is only lost when the FIFO is full and nothing leaves that cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (push_s && full_s && !pop_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge system_clock) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign rd_entry_s         = rd_word_s;
    assign bus.out_data       = rd_entry_s.data;
    assign bus.out_is_command = rd_entry_s.is_command;
    assign bus.out_valid      = ~empty_s;
    assign bus.level          = level_s;
    assign bus.overflow       = overflow_q;

endmodule

// File: tb/tb_mcu_bus_receiver.sv
// ---------------------------------------------------------------------------
// tb_mcu_bus_receiver
// Scoreboard bench for mcu_bus_receiver. Inputs change 1 time unit after a
// rising clock edge; outputs are sampled on the falling edge. Each strobe that
// should be stored pushes {flag, byte} onto a queue; every accepted output
// beat pops and compares the queue head.
// ---------------------------------------------------------------------------
module tb_mcu_bus_receiver;

    logic system_clock = 1'b0;
    logic reset        = 1'b1;
    int   n_cmp        = 0;
    int   n_bad        = 0;
    logic [8:0] exp_q[$];

    always #5 system_clock = ~system_clock;

    mcu_bus_receiver_if #(.DATA_WIDTH(8), .FIFO_DEPTH(8)) bus_if ();

    mcu_bus_receiver #(
        .DATA_WIDTH  (8),
        .FIFO_DEPTH  (8),
        .SYNC_STAGES (2)
    ) dut (
        .system_clock (system_clock),
        .reset        (reset),
        .bus          (bus_if)
    );

    // Single comparison point for the whole bench.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Output monitor: every accepted beat must match the scoreboard head.
    always @(negedge system_clock) begin
        if (!reset && bus_if.out_valid === 1'b1 && bus_if.out_ready === 1'b1) begin
            check_val("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check_val("sb_entry", {23'd0, bus_if.out_is_command, bus_if.out_data}, {23'd0, exp_q[0]});
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge system_clock);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        bus_if.mcu_bus_clock = 1'b0;
        bus_if.out_ready = 1'b0;
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One bus transfer: setup, strobe high 4 cycles, low 3 cycles.
    task automatic strobe(input logic [7:0] d, input logic cd, input bit store);
        tick();
        bus_if.mcu_bus = d;
        bus_if.mcu_bus_command_data = cd;
        if (store) exp_q.push_back({cd, d});
        tick();
        bus_if.mcu_bus_clock = 1'b1;
        repeat (4) tick();
        bus_if.mcu_bus_clock = 1'b0;
        repeat (3) tick();
    endtask

    // Drain with out_ready held high; returns number of cycles taken.
    task automatic drain(output int cycles);
        cycles = 0;
        bus_if.out_ready = 1'b1;
        while (exp_q.size() != 0 && cycles < 40) begin
            tick();
            cycles++;
        end
        bus_if.out_ready = 1'b0;
        check_val("drain_done", exp_q.size(), 32'd0);
        @(negedge system_clock);
        check_val("drain_valid", bus_if.out_valid, 32'd0);
        check_val("drain_level", bus_if.level, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        bus_if.mcu_bus_clock = 1'b0;
        bus_if.mcu_bus = 8'h00;
        bus_if.mcu_bus_command_data = 1'b0;
        bus_if.out_ready = 1'b0;

        // Reset state
        do_reset();
        @(negedge system_clock);
        check_val("rst_valid", bus_if.out_valid, 32'd0);
        check_val("rst_level", bus_if.level, 32'd0);
        check_val("rst_overflow", bus_if.overflow, 32'd0);
        check_val("rst_data", bus_if.out_data, 32'd0);
        check_val("rst_cmd", bus_if.out_is_command, 32'd0);

        // 1: latency of a single command byte
        tick();
        bus_if.mcu_bus = 8'hA5;
        bus_if.mcu_bus_command_data = 1'b1;
        exp_q.push_back({1'b1, 8'hA5});
        tick();
        bus_if.mcu_bus_clock = 1'b1;
        @(posedge system_clock);            // E0
        @(negedge system_clock);
        check_val("lat_e0_valid", bus_if.out_valid, 32'd0);
        @(posedge system_clock);            // E1
        @(negedge system_clock);
        check_val("lat_e1_valid", bus_if.out_valid, 32'd0);
        @(posedge system_clock);            // E2: entry written
        @(negedge system_clock);
        check_val("lat_e2_valid", bus_if.out_valid, 32'd1);
        check_val("lat_data", bus_if.out_data, 32'hA5);
        check_val("lat_cmd", bus_if.out_is_command, 32'd1);
        check_val("lat_level", bus_if.level, 32'd1);
        tick();
        bus_if.mcu_bus_clock = 1'b0;
        repeat (3) tick();
        drain(cyc);

        // 2: fill to 8 then drain one per cycle
        do_reset();
        for (int i = 0; i < 8; i++) strobe(8'(i), 1'(i & 1), 1'b1);
        @(negedge system_clock);
        check_val("fill_level", bus_if.level, 32'd8);
        check_val("fill_overflow", bus_if.overflow, 32'd0);
        tick();
        drain(cyc);
        check_val("fill_drain_cycles", cyc, 32'd8);

        // 3: push into full FIFO with no pop is dropped
        do_reset();
        for (int i = 0; i < 8; i++) strobe(8'(i), 1'b0, 1'b1);
        strobe(8'hFF, 1'b1, 1'b0);
        @(negedge system_clock);
        check_val("ovf_flag", bus_if.overflow, 32'd1);
        check_val("ovf_level", bus_if.level, 32'd8);
        tick();
        drain(cyc);
        check_val("ovf_drain_cycles", cyc, 32'd8);
        check_val("ovf_sticky", bus_if.overflow, 32'd1);
        repeat (3) tick();
        @(negedge system_clock);
        check_val("ovf_sticky_late", bus_if.overflow, 32'd1);

        // 4: push into full FIFO while popping
        do_reset();
        for (int i = 0; i < 8; i++) strobe(8'(i), 1'b0, 1'b1);
        tick();
        bus_if.mcu_bus = 8'h55;
        bus_if.mcu_bus_command_data = 1'b0;
        exp_q.push_back({1'b0, 8'h55});
        tick();
        bus_if.mcu_bus_clock = 1'b1;
        tick();                             // E0
        tick();                             // E1
        bus_if.out_ready = 1'b1;
        tick();                             // E2: push and pop together
        bus_if.out_ready = 1'b0;
        @(negedge system_clock);
        check_val("fullpop_level", bus_if.level, 32'd8);
        check_val("fullpop_overflow", bus_if.overflow, 32'd0);
        check_val("fullpop_head", bus_if.out_data, 32'h01);
        tick();
        bus_if.mcu_bus_clock = 1'b0;
        repeat (3) tick();
        drain(cyc);
        check_val("fullpop_drain_cycles", cyc, 32'd8);

        // 5: strobe held high through reset gives no push
        do_reset();
        tick();
        bus_if.mcu_bus_clock = 1'b1;
        reset = 1'b1;
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
        repeat (6) tick();
        @(negedge system_clock);
        check_val("hold_valid", bus_if.out_valid, 32'd0);
        check_val("hold_level", bus_if.level, 32'd0);
        tick();
        bus_if.mcu_bus_clock = 1'b0;
        repeat (3) tick();
        strobe(8'h3C, 1'b1, 1'b1);
        @(negedge system_clock);
        check_val("hold_one_level", bus_if.level, 32'd1);
        tick();
        drain(cyc);

        // 6: reset with buffered bytes and a strobe in the synchroniser
        do_reset();
        for (int i = 0; i < 5; i++) strobe(8'h10 + 8'(i), 1'b0, 1'b1);
        @(negedge system_clock);
        check_val("mid_level_pre", bus_if.level, 32'd5);
        tick();
        bus_if.mcu_bus = 8'h99;
        tick();
        bus_if.mcu_bus_clock = 1'b1;
        tick();                             // E0: rise in first sync stage
        reset = 1'b1;
        exp_q.delete();
        tick();
        reset = 1'b0;
        @(negedge system_clock);
        check_val("mid_level", bus_if.level, 32'd0);
        check_val("mid_valid", bus_if.out_valid, 32'd0);
        check_val("mid_overflow", bus_if.overflow, 32'd0);
        repeat (4) tick();
        bus_if.mcu_bus_clock = 1'b0;
        repeat (4) tick();
        @(negedge system_clock);
        check_val("mid_no_push_valid", bus_if.out_valid, 32'd0);
        check_val("mid_no_push_level", bus_if.level, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
